// File: rtl/param_dual_port_ram_if.sv
// param_dual_port_ram_if: write port (wr_en/wr_addr/wr_data/wr_be), read port (rd_en/rd_addr -> rd_data/rd_valid) and busy status
interface param_dual_port_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_be;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic                    busy;
  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, busy
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/param_dual_port_ram.sv
// param_dual_port_ram: byte-enabled simple dual-port RAM with registered read, selectable read-during-write and post-reset clear; ports clk, rst, bus (slave)
module param_dual_port_ram #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic                 clk,
  input logic                 rst,
  param_dual_port_ram_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] merged, wdata;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [NB-1:0]         be_eff;
  logic                  clearing, we, collide;
  assign clearing = state == CLEAR;
  assign bus.busy = clearing;
  always_comb begin
    state_nxt = (clearing && &ptr) ? RUN : state;
    ptr_nxt   = clearing ? ptr + 1'b1 : ptr;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR_ON_RESET != 0 ? CLEAR : RUN;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  for (genvar i = 0; i < NB; i++) begin : g_merge
    assign merged[8*i +: 8] = bus.wr_be[i] ? bus.wr_data[8*i +: 8] : mem[bus.wr_addr][8*i +: 8];
  end
  assign we      = !rst && (clearing || bus.wr_en);
  assign waddr   = clearing ? ptr : bus.wr_addr;
  assign wdata   = clearing ? '0 : bus.wr_data;
  assign be_eff  = clearing ? '1 : bus.wr_be;
  assign collide = bus.wr_en && bus.wr_addr == bus.rd_addr;
  always_ff @(posedge clk)
    if (we)
      for (int b = 0; b < NB; b++)
        if (be_eff[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
  always_ff @(posedge clk)
    if (rst) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= !clearing && bus.rd_en;
      if (!clearing && bus.rd_en)
        bus.rd_data <= (RDW_MODE == 1 && collide) ? merged : mem[bus.rd_addr];
    end
endmodule
